// File: rtl/plot_sink_fb_pkg.sv
// Shared constants, FSM state type and framebuffer address mapping for the
// VGA plot sink.
package plot_sink_pkg;

  localparam int FB_W    = 160;
  localparam int FB_H    = 120;
  localparam int FB_SIZE = FB_W * FB_H;
  localparam int ADDR_W  = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SCAN  = 2'd2
  } state_t;

  // Raster address, x fastest.
  function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [7:0] x,
                                                  input logic [6:0] y);
    return ADDR_W'(y) * ADDR_W'(FB_W) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/plot_sink_fb_if.sv
// Scan-out pixel stream: valid/ready handshake carrying one framebuffer pixel
// per accepted beat.
interface plot_sink_fb_if #(parameter int CW = 3);
  logic [7:0]    pix_x;
  logic [6:0]    pix_y;
  logic [CW-1:0] pix_colour;
  logic          pix_valid;
  logic          pix_ready;
  logic          pix_last;

  modport master (
    output pix_x, pix_y, pix_colour, pix_valid, pix_last,
    input  pix_ready
  );

  modport slave (
    input  pix_x, pix_y, pix_colour, pix_valid, pix_last,
    output pix_ready
  );
endinterface

// File: rtl/plot_sink_fb_ram.sv
// Simple dual-port framebuffer memory: one write port, one registered read
// port with read-before-write behaviour on address collision.
module fb_ram
  import plot_sink_pkg::*;
#(
  parameter int CW = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [CW-1:0]     wd,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra,
  output logic [CW-1:0]     rq
);

  logic [CW-1:0] mem [FB_SIZE];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  // Separate process keeps the old-data read on a same-address write.
  always_ff @(posedge clk) begin
    if (re) rq <= mem[ra];
  end

endmodule

// File: rtl/plot_sink_fb.sv
// VGA plot sink: captures plotted pixels into a framebuffer and offers a
// hardware clear and a raster-order valid/ready scan-out readback.
module plot_sink_fb
  import plot_sink_pkg::*;
#(
  parameter int FB_W = 160,
  parameter int FB_H = 120,
  parameter int CW   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           vga_x,
  input  logic [6:0]           vga_y,
  input  logic [CW-1:0]        vga_colour,
  input  logic                 vga_plot,
  input  logic                 start_clear,
  input  logic [CW-1:0]        clear_colour,
  input  logic                 start_scan,
  plot_sink_fb_if.master       pix,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          oob_count
);

  localparam logic [7:0]        X_LIM  = 8'(FB_W);
  localparam logic [6:0]        Y_LIM  = 7'(FB_H);
  localparam logic [7:0]        X_LAST = 8'(FB_W - 1);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(FB_SIZE - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_addr;
  logic [CW-1:0]     clr_colour;

  logic [ADDR_W-1:0] iss_addr;
  logic [7:0]        iss_x;
  logic [6:0]        iss_y;
  logic              iss_more;

  logic              vld_p1;
  logic [7:0]        x_p1;
  logic [6:0]        y_p1;
  logic              last_p1;
  logic [CW-1:0]     rd_q;

  logic              in_range, clr_last, issue, load_out, beat_last;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [CW-1:0]     wd;

  assign in_range  = (vga_x < X_LIM) && (vga_y < Y_LIM);
  assign clr_last  = (clr_addr == A_LAST);
  // Read only when the output register is empty or draining this cycle.
  assign issue     = (state == SCAN) && iss_more && (!pix.pix_valid || pix.pix_ready);
  assign load_out  = vld_p1 && (!pix.pix_valid || pix.pix_ready);
  assign beat_last = (state == SCAN) && pix.pix_valid && pix.pix_ready && pix.pix_last;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_clear)     state_nxt = CLEAR;
        else if (start_scan) state_nxt = SCAN;
      end
      CLEAR:   if (clr_last)  state_nxt = IDLE;
      SCAN:    if (beat_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    we = 1'b0;
    wa = xy_to_addr(vga_x, vga_y);
    wd = vga_colour;
    if (state == CLEAR) begin
      we = 1'b1;
      wa = clr_addr;
      wd = clr_colour;
    end else begin
      we = vga_plot && in_range;
    end
  end

  fb_ram #(.CW(CW)) u_ram (
    .clk (clk),
    .we  (we),
    .wa  (wa),
    .wd  (wd),
    .re  (issue),
    .ra  (iss_addr),
    .rq  (rd_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      done      <= 1'b0;
      clr_addr  <= '0;
      oob_count <= '0;
    end else begin
      state <= state_nxt;
      done  <= ((state == CLEAR) && clr_last) || beat_last;
      if ((state == IDLE) && start_clear) clr_addr <= '0;
      else if (state == CLEAR)            clr_addr <= clr_addr + 1'b1;
      if ((state != CLEAR) && vga_plot && !in_range && (oob_count != 16'hFFFF))
        oob_count <= oob_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if ((state == IDLE) && start_clear) clr_colour <= clear_colour;
  end

  // p0: scan read issue counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_addr <= '0;
      iss_x    <= '0;
      iss_y    <= '0;
      iss_more <= 1'b0;
    end else if ((state == IDLE) && start_scan && !start_clear) begin
      iss_addr <= '0;
      iss_x    <= '0;
      iss_y    <= '0;
      iss_more <= 1'b1;
    end else if (issue) begin
      iss_addr <= iss_addr + 1'b1;
      if (iss_x == X_LAST) begin
        iss_x <= '0;
        iss_y <= iss_y + 1'b1;
      end else begin
        iss_x <= iss_x + 1'b1;
      end
      if (iss_addr == A_LAST) iss_more <= 1'b0;
    end
  end

  // p1: RAM data out, coordinates travel alongside
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        vld_p1 <= 1'b0;
    else if (issue)    vld_p1 <= 1'b1;
    else if (load_out) vld_p1 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      x_p1    <= iss_x;
      y_p1    <= iss_y;
      last_p1 <= (iss_addr == A_LAST);
    end
  end

  // p2: output register, held while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix.pix_valid  <= 1'b0;
      pix.pix_x      <= '0;
      pix.pix_y      <= '0;
      pix.pix_colour <= '0;
      pix.pix_last   <= 1'b0;
    end else if (load_out) begin
      pix.pix_valid  <= 1'b1;
      pix.pix_x      <= x_p1;
      pix.pix_y      <= y_p1;
      pix.pix_colour <= rd_q;
      pix.pix_last   <= last_p1;
    end else if (pix.pix_valid && pix.pix_ready) begin
      pix.pix_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_plot_sink_fb.sv
// Directed bench for plot_sink_fb: clear, plot table, stalled scan-out,
// command priority and asynchronous reset mid-scan.
module tb_plot_sink_fb;

  localparam int W  = 160;
  localparam int H  = 120;
  localparam int SZ = W * H;

  logic       clk, rst_n;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       start_clear, start_scan;
  logic [2:0] clear_colour;
  logic       busy, done;
  logic [15:0] oob_count;

  plot_sink_fb_if #(.CW(3)) pix_if ();

  plot_sink_fb #(.FB_W(W), .FB_H(H), .CW(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vga_x        (vga_x),
    .vga_y        (vga_y),
    .vga_colour   (vga_colour),
    .vga_plot     (vga_plot),
    .start_clear  (start_clear),
    .clear_colour (clear_colour),
    .start_scan   (start_scan),
    .pix          (pix_if),
    .busy         (busy),
    .done         (done),
    .oob_count    (oob_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int oob_exp = 0;
  logic [2:0] model [SZ];

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    int         oob;
  } plot_vec_t;

  plot_vec_t pv [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic run_clear(input logic [2:0] col, input bit also_scan, input bit noise);
    int n;
    int oob_before;
    oob_before   = 32'(oob_count);
    clear_colour = col;
    start_clear  = 1'b1;
    start_scan   = also_scan;
    tick();
    start_clear  = 1'b0;
    start_scan   = 1'b0;
    clear_colour = ~col;
    n = 0;
    while (busy && n < 20000) begin
      vga_plot   = 1'b0;
      start_scan = 1'b0;
      if (noise && n == 100) begin
        vga_x = 8'd5;   vga_y = 7'd5; vga_colour = 3'd7; vga_plot = 1'b1;
      end
      if (noise && n == 101) begin
        vga_x = 8'd200; vga_y = 7'd3; vga_colour = 3'd7; vga_plot = 1'b1;
      end
      if (noise && n == 102) start_scan = 1'b1;
      tick();
      n++;
    end
    vga_plot   = 1'b0;
    start_scan = 1'b0;
    chk("clear_busy_cycles", 32'(n), 32'(SZ));
    chk("clear_done_pulse", 32'(done), 32'd1);
    chk("clear_oob_unchanged", 32'(oob_count), 32'(oob_before));
    tick();
    chk("clear_done_low", 32'(done), 32'd0);
    tick();
    tick();
    chk("clear_no_scan_valid", 32'(pix_if.pix_valid), 32'd0);
    chk("clear_back_idle", 32'(busy), 32'd0);
    for (int i = 0; i < SZ; i++) model[i] = col;
  endtask

  task automatic run_scan(input bit rnd, input int stop_at);
    int k, cyc, lat, dat_err, last_err, stab_err;
    bit stall;
    logic [7:0] sx;
    logic [6:0] sy;
    logic [2:0] sc;
    logic       sl;
    pix_if.pix_ready = 1'b1;
    start_scan = 1'b1;
    tick();
    start_scan = 1'b0;
    lat = 0;
    while (!pix_if.pix_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk("scan_first_valid_latency", 32'(lat), 32'd2);
    k = 0; cyc = 0; stall = 0;
    dat_err = 0; last_err = 0; stab_err = 0;
    sx = '0; sy = '0; sc = '0; sl = 1'b0;
    while (k < SZ && cyc < 60000) begin
      if (stop_at >= 0 && k == stop_at) break;
      pix_if.pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pix_if.pix_valid) begin
        if (stall && ({pix_if.pix_x, pix_if.pix_y, pix_if.pix_colour, pix_if.pix_last}
                      !== {sx, sy, sc, sl}))
          stab_err++;
        if (pix_if.pix_ready) begin
          if (pix_if.pix_x !== 8'(k % W) || pix_if.pix_y !== 7'(k / W) ||
              pix_if.pix_colour !== model[k]) begin
            if (dat_err < 4)
              $display("  pixel %0d got (%0d,%0d,c%0d)", k, pix_if.pix_x, pix_if.pix_y,
                       pix_if.pix_colour);
            dat_err++;
          end
          if (pix_if.pix_last !== (k == SZ - 1)) last_err++;
          k++;
          stall = 0;
        end else begin
          stall = 1;
          sx = pix_if.pix_x; sy = pix_if.pix_y; sc = pix_if.pix_colour; sl = pix_if.pix_last;
        end
      end else if (stall) begin
        stab_err++;
        stall = 0;
      end
      tick();
      cyc++;
    end
    chk("scan_pixel_data", 32'(dat_err), 32'd0);
    chk("scan_last_flag", 32'(last_err), 32'd0);
    chk("scan_stall_stable", 32'(stab_err), 32'd0);
    if (stop_at >= 0) begin
      chk("scan_beats_before_reset", 32'(k), 32'(stop_at));
      chk("abort_valid_before", 32'(pix_if.pix_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_valid_low", 32'(pix_if.pix_valid), 32'd0);
      chk("abort_busy_low", 32'(busy), 32'd0);
      chk("abort_done_low", 32'(done), 32'd0);
      chk("abort_pix_x_zero", 32'(pix_if.pix_x), 32'd0);
      oob_exp = 0;
      tick();
      rst_n = 1'b1;
      tick();
    end else begin
      chk("scan_beats", 32'(k), 32'(SZ));
      chk("scan_done_pulse", 32'(done), 32'd1);
      chk("scan_valid_dropped", 32'(pix_if.pix_valid), 32'd0);
      chk("scan_back_idle", 32'(busy), 32'd0);
      tick();
      chk("scan_done_low", 32'(done), 32'd0);
    end
    pix_if.pix_ready = 1'b1;
  endtask

  initial begin
    pv[0] = '{x: 8'd80,  y: 7'd60,  c: 3'd2, oob: 0};
    pv[1] = '{x: 8'd0,   y: 7'd0,   c: 3'd7, oob: 0};
    pv[2] = '{x: 8'd160, y: 7'd5,   c: 3'd1, oob: 1};
    pv[3] = '{x: 8'd5,   y: 7'd120, c: 3'd1, oob: 2};
    pv[4] = '{x: 8'd255, y: 7'd127, c: 3'd1, oob: 3};
    pv[5] = '{x: 8'd159, y: 7'd119, c: 3'd4, oob: 3};
    pv[6] = '{x: 8'd1,   y: 7'd0,   c: 3'd3, oob: 3};

    rst_n = 1'b0;
    vga_x = '0; vga_y = '0; vga_colour = '0; vga_plot = 1'b0;
    start_clear = 1'b0; start_scan = 1'b0; clear_colour = '0;
    pix_if.pix_ready = 1'b1;
    tick();
    tick();
    chk("rst_pix_valid", 32'(pix_if.pix_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_oob", 32'(oob_count), 32'd0);
    chk("rst_pix_last", 32'(pix_if.pix_last), 32'd0);
    rst_n = 1'b1;
    tick();

    // Clear to 0 with a plot, an oob plot and a scan request injected mid-clear.
    run_clear(3'd0, 1'b0, 1'b1);

    for (int i = 0; i < 7; i++) begin
      vga_x = pv[i].x; vga_y = pv[i].y; vga_colour = pv[i].c; vga_plot = 1'b1;
      tick();
      vga_plot = 1'b0;
      if (pv[i].x < 8'(W) && pv[i].y < 7'(H))
        model[int'(pv[i].y) * W + int'(pv[i].x)] = pv[i].c;
      chk($sformatf("oob_after_plot%0d", i), 32'(oob_count), 32'(pv[i].oob));
    end
    chk("model_pixel_9680", 32'(model[9680]), 32'd2);

    run_scan(1'b1, -1);

    // Simultaneous requests: clear wins, scan discarded.
    run_clear(3'd5, 1'b1, 1'b0);

    vga_x = 8'd3; vga_y = 7'd2; vga_colour = 3'd6; vga_plot = 1'b1;
    tick();
    vga_plot = 1'b0;
    model[2 * W + 3] = 3'd6;

    run_scan(1'b0, 500);
    chk("post_reset_oob", 32'(oob_count), 32'(oob_exp));
    run_scan(1'b0, 1200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
